// File: rtl/mem_arbiter.sv
// Main-memory arbiter and cache-block fill sequencer shared by the I-cache miss
// path and the D-cache miss/write-through path of the 16-bit pipelined CPU.
//
// state | meaning
// IDLE  | no operation; arbitrate d_wr > d_miss > i_miss on each edge
// STORE | single-cycle write-through of the latched store, d_done pulses
// FILL  | issue WORDS pipelined reads, write returned words into the cache
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        fill_we,
    output logic        fill_sel,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        FILL  = 2'd2
    } state_t;

    // The block address layout {base, word, byte} only works for 8-word blocks.
    if (WORDS != 8 || MEM_LAT < 1) begin : g_param_check
        $error("mem_arbiter: WORDS must be 8 and MEM_LAT at least 1");
    end

    localparam logic [3:0] IC_END  = 4'(WORDS);
    localparam logic [2:0] RC_LAST = 3'(WORDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  ic_q, ic_d;
    logic [2:0]  rc_q, rc_d;
    logic [11:0] base_q, base_d;
    logic        sel_q, sel_d;
    logic [15:0] saddr_q, saddr_d;
    logic [15:0] sdata_q, sdata_d;

    logic last_word;
    logic unused_addr_bits;

    assign last_word        = (state_q == FILL) && mem_valid && (rc_q == RC_LAST);
    assign unused_addr_bits = ^i_addr[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ic_q    <= '0;
            rc_q    <= '0;
            base_q  <= '0;
            sel_q   <= 1'b0;
            saddr_q <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            base_q  <= base_d;
            sel_q   <= sel_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_wr) begin
                    state_d = STORE;
                end else if (d_miss || i_miss) begin
                    state_d = FILL;
                end
            end
            STORE:   state_d = IDLE;
            FILL:    if (last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant capture and fill counters; counters are cleared on leaving FILL
    // so a stray mem_valid while idle never disturbs them.
    always_comb begin
        ic_d    = ic_q;
        rc_d    = rc_q;
        base_d  = base_q;
        sel_d   = sel_q;
        saddr_d = saddr_q;
        sdata_d = sdata_q;
        case (state_q)
            IDLE: begin
                if (d_wr) begin
                    saddr_d = d_addr;
                    sdata_d = d_wdata;
                    base_d  = d_addr[15:4];
                    sel_d   = 1'b1;
                end else if (d_miss) begin
                    base_d = d_addr[15:4];
                    sel_d  = 1'b1;
                end else if (i_miss) begin
                    base_d = i_addr[15:4];
                    sel_d  = 1'b0;
                end
            end
            FILL: begin
                if (ic_q < IC_END) begin
                    ic_d = ic_q + 4'd1;
                end
                if (mem_valid) begin
                    rc_d = rc_q + 3'd1;
                end
                if (last_word) begin
                    ic_d = '0;
                    rc_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we   = 1'b0;
        fill_sel  = 1'b0;
        fill_word = '0;
        fill_data = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            STORE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = saddr_q;
                mem_wdata = sdata_q;
                d_done    = 1'b1;
            end
            FILL: begin
                if (ic_q < IC_END) begin
                    mem_en   = 1'b1;
                    mem_addr = {base_q, ic_q[2:0], 1'b0};
                end
                if (mem_valid) begin
                    fill_we   = 1'b1;
                    fill_sel  = sel_q;
                    fill_word = rc_q;
                    fill_data = mem_rdata;
                end
                if (last_word) begin
                    i_done = !sel_q;
                    d_done = sel_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: pipelined memory model, an operation
// schedule model checked every cycle, and directed scenarios with literal checks.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int WORDS   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        mem_en, mem_wr, mem_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fill_we, fill_sel, i_done, d_done, busy;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;

    logic        spur;
    logic [15:0] spur_data;

    int checks   = 0;
    int failures = 0;
    int tid      = 0;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: a read issued in cycle k returns its data in cycle k+MEM_LAT.
    logic        pv [MEM_LAT];
    logic [15:0] pd [MEM_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= mem_en && !mem_wr;
            pd[0] <= memf(mem_addr);
            for (int k = 1; k < MEM_LAT; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end
    assign mem_valid = pv[MEM_LAT-1] | spur;
    assign mem_rdata = spur ? spur_data : (pv[MEM_LAT-1] ? pd[MEM_LAT-1] : 16'h0000);

    // Operation schedule model: kind 0 none, 1 store, 2 fill; t = cycle within op.
    int          m_kind  = 0;
    int          m_t     = 0;
    logic [11:0] m_base  = '0;
    logic        m_sel   = 1'b0;
    logic [15:0] m_saddr = '0;
    logic [15:0] m_sdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind = 0;
            m_t    = 0;
        end else if (m_kind == 0) begin
            if (d_wr) begin
                m_kind = 1; m_t = 1; m_saddr = d_addr; m_sdata = d_wdata;
            end else if (d_miss) begin
                m_kind = 2; m_t = 1; m_base = d_addr[15:4]; m_sel = 1'b1;
            end else if (i_miss) begin
                m_kind = 2; m_t = 1; m_base = i_addr[15:4]; m_sel = 1'b0;
            end
        end else if (m_kind == 1 || m_t == WORDS + MEM_LAT) begin
            m_kind = 0;
            m_t    = 0;
        end else begin
            m_t++;
        end
    end

    always @(negedge clk) begin
        logic        e_issue, e_fwe, e_last;
        logic [15:0] e_addr, e_waddr;
        int          wi;
        e_issue = (m_kind == 2) && (m_t <= WORDS);
        e_fwe   = (m_kind == 2) && (m_t > MEM_LAT) && (m_t <= WORDS + MEM_LAT);
        e_last  = (m_kind == 2) && (m_t == WORDS + MEM_LAT);
        wi      = e_fwe ? (m_t - MEM_LAT - 1) : 0;
        e_addr  = (m_kind == 1) ? m_saddr :
                  e_issue ? ({m_base, 4'h0} + 16'((m_t - 1) * 2)) : 16'h0000;
        e_waddr = {m_base, 4'h0} + 16'(wi * 2);
        chk("mem_en",    16'(mem_en),    16'(m_kind == 1 || e_issue));
        chk("mem_wr",    16'(mem_wr),    16'(m_kind == 1));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", mem_wdata,      (m_kind == 1) ? m_sdata : 16'h0000);
        chk("fill_we",   16'(fill_we),   16'(e_fwe));
        chk("fill_sel",  16'(fill_sel),  16'(e_fwe && m_sel));
        chk("fill_word", 16'(fill_word), 16'(wi));
        chk("fill_data", fill_data,      e_fwe ? memf(e_waddr) : 16'h0000);
        chk("i_done",    16'(i_done),    16'(e_last && !m_sel));
        chk("d_done",    16'(d_done),    16'(m_kind == 1 || (e_last && m_sel)));
        chk("busy",      16'(busy),      16'(m_kind != 0));
    end

    task automatic lit(input int cyc);
        case (tid)
            1: begin
                if (cyc == 1)  chk("lit_i_addr_c1", mem_addr, 16'h1230);
                if (cyc == 8)  chk("lit_i_addr_c8", mem_addr, 16'h123E);
                if (cyc == 5)  chk("lit_i_fword_c5", 16'(fill_word), 16'd0);
                if (cyc == 5)  chk("lit_i_fdata_c5", fill_data, 16'h480C);
                if (cyc == 11) chk("lit_i_done_c11", 16'(i_done), 16'd0);
                if (cyc == 12) chk("lit_i_done_c12", 16'(i_done), 16'd1);
                if (cyc == 12) chk("lit_i_fword_c12", 16'(fill_word), 16'd7);
                if (cyc == 13) chk("lit_i_busy_c13", 16'(busy), 16'd0);
            end
            2: begin
                if (cyc == 5)  chk("lit_di_sel_c5", 16'(fill_sel), 16'd1);
                if (cyc == 12) chk("lit_di_ddone_c12", 16'(d_done), 16'd1);
                if (cyc == 14) chk("lit_di_addr_c14", mem_addr, 16'h2000);
                if (cyc == 25) chk("lit_di_idone_c25", 16'(i_done), 16'd1);
            end
            3: begin
                if (cyc == 1) chk("lit_st_wr_c1", {15'd0, mem_wr}, 16'd1);
                if (cyc == 1) chk("lit_st_addr_c1", mem_addr, 16'h0040);
                if (cyc == 1) chk("lit_st_wdata_c1", mem_wdata, 16'hBEEF);
                if (cyc == 1) chk("lit_st_ddone_c1", 16'(d_done), 16'd1);
                if (cyc == 2) chk("lit_st_en_c2", 16'(mem_en), 16'd0);
                if (cyc == 3) chk("lit_st_fill_addr_c3", mem_addr, 16'h3000);
            end
            5: begin
                if (cyc == 1)  chk("lit_rst_restart_addr", mem_addr, 16'h5670);
                if (cyc == 5)  chk("lit_rst_restart_word", 16'(fill_word), 16'd0);
                if (cyc == 12) chk("lit_rst_restart_done", 16'(i_done), 16'd1);
            end
            6: begin
                if (cyc == 5) chk("lit_spur_word0", 16'(fill_word), 16'd0);
                if (cyc == 5) chk("lit_spur_data0", fill_data, 16'h5A2C);
            end
            default: ;
        endcase
    endtask

    // Runs n cycles after a grant; requesters drop when their done pulse is seen.
    task automatic run(input int n, input int rst_at);
        int   cyc    = 0;
        bit   pulsed = 0;
        logic id, dd;
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
            lit(cyc);
            id = i_done;
            dd = d_done;
            #1;
            if (id) i_miss = 1'b0;
            if (dd) begin
                d_miss = 1'b0;
                d_wr   = 1'b0;
            end
            if (!pulsed && rst_at != 0 && cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_pulse_outputs", {mem_en, mem_wr, fill_we, i_done, d_done, busy, fill_word}, 16'd0);
                chk("rst_pulse_addr", mem_addr, 16'h0000);
                #1;
                rst_n  = 1'b1;
                pulsed = 1;
                cyc    = 0;
                tid    = 5;
            end
        end
        chk("req_released", {13'd0, i_miss, d_miss, d_wr}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        spur = 1'b0; spur_data = '0;

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            i_miss    = 1'($urandom_range(0, 1));
            d_miss    = 1'($urandom_range(0, 1));
            d_wr      = 1'($urandom_range(0, 1));
            i_addr    = 16'($urandom);
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            spur      = 1'($urandom_range(0, 1));
            spur_data = 16'($urandom);
        end
        @(negedge clk);
        chk("in_reset_busy", 16'(busy), 16'd0);
        chk("in_reset_mem_addr", mem_addr, 16'h0000);
        #1;
        i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0; spur = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {mem_en, fill_we, busy, i_done, d_done}, 16'd0);
        #1;

        tid = 1;
        i_addr = 16'h1236; i_miss = 1'b1;
        run(14, 0);

        tid = 2;
        d_addr = 16'h0400; i_addr = 16'h2000; d_miss = 1'b1; i_miss = 1'b1;
        run(27, 0);

        tid = 3;
        d_addr = 16'h0040; d_wdata = 16'hBEEF; d_wr = 1'b1;
        i_addr = 16'h3000; i_miss = 1'b1;
        run(16, 0);

        tid = 4;
        i_addr = 16'h567A; i_miss = 1'b1;
        run(14, 6);

        tid = 6;
        spur = 1'b1; spur_data = 16'hFFFF;
        @(negedge clk);
        chk("spur_fill_we", 16'(fill_we), 16'd0);
        #1;
        spur = 1'b0;
        i_addr = 16'h0010; i_miss = 1'b1;
        run(14, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle main-memory arbiter and cache-fill sequencer for the 16-bit pipelined CPU. It shares the single-ported, pipelined main memory between the instruction-cache miss path and the data-cache path. The data path covers both miss fills and write-through stores from SW. It sits between the two cache controllers and the memory model. It generates block-fill write strobes and per-requester completion pulses that release the pipeline stall logic.

## Interface
Parameters:
- MEM_LAT, 4: cycles from a read issue (mem_en=1, mem_wr=0) to its mem_valid.
- WORDS, 8: 16-bit words per cache block (16-byte block). Fixed at 8 for this ISA.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_miss  in  1  I-cache miss request; held high until i_done
- i_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache miss request; held high until d_done
- d_addr  in  16  D-cache miss/store byte address
- d_wr  in  1  write-through store request (SW); held high until d_done
- d_wdata  in  16  store data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  mem_rdata valid
- fill_we  out  1  write one word into the selected cache's data array
- fill_sel  out  1  0 = I-cache, 1 = D-cache
- fill_word  out  3  word index within the block
- fill_data  out  16  word to write
- i_done  out  1  one-cycle pulse when the I fill completes
- d_done  out  1  one-cycle pulse when the D fill or store completes
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, STORE, FILL.
- IDLE: arbitration takes place on each rising edge. Fixed priority is d_wr > d_miss > i_miss.
  - Grant to d_wr → STORE.
  - Grant to d_miss or i_miss → FILL.
  - At grant, the block registers the block base addr[15:4], the requester id (fill_sel), and for stores d_addr and d_wdata.
- STORE (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr = latched d_addr, mem_wdata = latched data.
  - d_done=1 in the same cycle. Next state is IDLE.
- FILL:
  - Issue counter ic runs 0..7. While ic<8: mem_en=1, mem_wr=0, mem_addr = {base, ic[2:0], 1'b0}, then ic increments.
  - Receive counter rc runs 0..7. On each mem_valid: fill_we=1, fill_word=rc, fill_data=mem_rdata, then rc increments.
  - The cycle in which mem_valid arrives with rc==7 asserts the done pulse for the owning requester. Next state is IDLE.
- Requests are not preempted. A higher-priority request that arrives during FILL waits for IDLE.
- Requester deasserting during FILL: the fill still completes and the done pulse still fires.
- mem_valid in IDLE or STORE is ignored: no fill_we, counters unchanged.
- Outputs not actively driven are 0. This includes mem_addr, mem_wdata, fill_data and fill_word.
- Reset (async, any state): state=IDLE, ic=rc=0, all outputs 0.
  - Any in-flight reads are abandoned.
  - A still-asserted request is re-arbitrated from word 0 after rst_n deasserts.

## Timing
- Cycle 0: request sampled high in IDLE at the edge.
- Fill:
  - mem_en reads in cycles 1-8 (words 0-7).
  - fill_we in cycles 1+MEM_LAT .. 8+MEM_LAT (cycles 5-12 by default).
  - done in cycle 12; IDLE in cycle 13. FILL occupancy is WORDS+MEM_LAT cycles.
- Store: STORE in cycle 1 with d_done in cycle 1; IDLE in cycle 2.
- Back-to-back: the next grant is sampled at the end of the first IDLE cycle. Minimum one IDLE cycle separates operations.
- busy is 1 from the first STORE/FILL cycle through the done cycle inclusive.

## Test plan
- Reset: rst_n=0 with random inputs → all outputs 0, busy=0. After release with no requests, still all 0.
- Single I miss, i_addr=0x1236:
  - mem_addr 0x1230,0x1232,…,0x123E on cycles 1-8.
  - fill_we cycles 5-12 with fill_word 0-7, fill_sel=0, fill_data = returned memory words.
  - i_done only in cycle 12.
- i_miss and d_miss asserted together (d_addr=0x0400, i_addr=0x2000):
  - D fill first: fill_sel=1, d_done cycle 12.
  - Then I fill: mem_addr 0x2000 on cycle 14, i_done cycle 25.
- d_wr (d_addr=0x0040, d_wdata=0xBEEF) with i_miss high:
  - Cycle 1: mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_done=1.
  - I fill begins issuing on cycle 3.
- rst_n pulsed low during cycle 6 of an I fill → outputs 0 immediately. With i_miss still high after release, a new fill restarts at word 0 with the original base.
- Spurious mem_valid=1, mem_rdata=0xFFFF in IDLE → fill_we stays 0. A following fill still writes fill_word 0 first.
